// File: rtl/ice_response_parser.sv
//==============================================================================
// Module   : ice_response_parser
// Purpose  : Decodes ICE UART response frames ('a'/'c' + hex pairs + LF) into
//            tagged bytes on a valid/ready FIFO, with per-frame status.
// Options  : PARSER_TIMEOUT_EN enables the mid-frame idle timeout.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module ice_response_parser #(
    parameter int FIFO_DEPTH_LOG2 = 3,
    parameter int TIMEOUT_CYCLES  = 20000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] rx_data,
    input  logic       rx_latch,
    output logic [7:0] out_data,
    output logic       out_iface,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       frame_start,
    output logic       frame_done,
    output logic [7:0] frame_len,
    output logic       frame_err,
    output logic       overflow
);

    localparam int         DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam logic [7:0] C_CHR_A = 8'h61;
    localparam logic [7:0] C_CHR_C = 8'h63;
    localparam logic [7:0] C_LF    = 8'h0a;
    localparam logic [7:0] C_CR    = 8'h0d;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HI      = 2'd1,
        S_LO      = 2'd2,
        S_DISCARD = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_iface;
    logic [3:0]             r_hi;
    logic [7:0]             r_len;
    logic                   r_err;
    logic [8:0]             r_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0] r_wr_ptr;
    logic [FIFO_DEPTH_LOG2:0] r_rd_ptr;

    logic       w_char;
    logic       w_is_hex;
    logic [3:0] w_nib;
    logic       w_empty;
    logic       w_full;
    logic       w_pop;
    logic       w_push_req;
    logic       w_push_ok;
    logic       w_timeout;

    always_comb begin
        w_is_hex = 1'b0;
        w_nib    = 4'd0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            w_is_hex = 1'b1;
            w_nib    = rx_data[3:0];
        end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                     (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
            w_is_hex = 1'b1;
            w_nib    = rx_data[3:0] + 4'd9;
        end
    end

    // CR is transparent in every state, so it never counts as a character.
    assign w_char     = rx_latch && (rx_data != C_CR);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[FIFO_DEPTH_LOG2] != r_rd_ptr[FIFO_DEPTH_LOG2]) &&
                        (r_wr_ptr[FIFO_DEPTH_LOG2-1:0] == r_rd_ptr[FIFO_DEPTH_LOG2-1:0]);
    assign w_pop      = !w_empty && out_ready;
    assign w_push_req = w_char && (r_state == S_LO) && w_is_hex;
    assign w_push_ok  = w_push_req && (!w_full || w_pop);

    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? 8'd0 : r_mem[r_rd_ptr[FIFO_DEPTH_LOG2-1:0]][7:0];
    assign out_iface  = w_empty ? 1'b0 : r_mem[r_rd_ptr[FIFO_DEPTH_LOG2-1:0]][8];

`ifdef PARSER_TIMEOUT_EN
    localparam int C_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [C_TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tmo_cnt <= '0;
        end else if (rx_latch || (r_state == S_IDLE) || w_timeout) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = (r_state != S_IDLE) && !rx_latch &&
                       (r_tmo_cnt == C_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    logic [31:0] w_unused_tmo;
    assign w_unused_tmo = TIMEOUT_CYCLES;
    assign w_timeout    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= {r_iface, r_hi, w_nib};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_iface     <= 1'b0;
            r_hi        <= 4'd0;
            r_len       <= 8'd0;
            r_err       <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_len   <= 8'd0;
            frame_err   <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            if (w_push_req && !w_push_ok) overflow <= 1'b1;

            if (w_timeout) begin
                frame_done <= 1'b1;
                frame_len  <= r_len;
                frame_err  <= 1'b1;
                r_state    <= S_IDLE;
            end else if (w_char) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == C_CHR_A || rx_data == C_CHR_C) begin
                            r_state     <= S_HI;
                            r_iface     <= (rx_data == C_CHR_C);
                            r_len       <= 8'd0;
                            r_err       <= 1'b0;
                            frame_start <= 1'b1;
                        end
                    end
                    S_HI: begin
                        if (w_is_hex) begin
                            r_hi    <= w_nib;
                            r_state <= S_LO;
                        end else if (rx_data == C_LF) begin
                            frame_done <= 1'b1;
                            frame_len  <= r_len;
                            frame_err  <= r_err;
                            r_state    <= S_IDLE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_DISCARD;
                        end
                    end
                    S_LO: begin
                        if (w_is_hex) begin
                            // Dropped bytes still count toward the frame length.
                            r_len   <= (r_len == 8'hff) ? r_len : r_len + 8'd1;
                            if (!w_push_ok) r_err <= 1'b1;
                            r_state <= S_HI;
                        end else if (rx_data == C_LF) begin
                            frame_done <= 1'b1;
                            frame_len  <= r_len;
                            frame_err  <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_err   <= 1'b1;
                            r_state <= S_DISCARD;
                        end
                    end
                    S_DISCARD: begin
                        if (rx_data == C_LF) begin
                            frame_done <= 1'b1;
                            frame_len  <= r_len;
                            frame_err  <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/ice_response_parser.md
Name: ice_response_parser

Overview:
- Host-side decoder for the ICE controller's UART response stream.
- Consumes received UART bytes and recognises frames: 'a' (0x61, PINT) or 'c' (0x63, discrete I2C), then hex character pairs, then LF (0x0a).
- Emits decoded bytes through a valid/ready FIFO tagged with the source interface, plus per-frame start/done/length/error status.
- Sits behind a uart instance in loopback benches and in a bridge FPGA that talks to ICE.

Parameters:
FIFO_DEPTH_LOG2, 3, log2 of output FIFO depth (8 entries of {iface, byte}).
TIMEOUT_CYCLES, 20000, idle cycles before mid-frame abort (1 ms at 20 MHz); used only with PARSER_TIMEOUT_EN.

Ports:
clk  input  1  system clock.
resetn  input  1  asynchronous, active-low reset.
rx_data  input  8  received UART character.
rx_latch  input  1  one-cycle strobe, rx_data valid.
out_data  output  8  decoded byte at FIFO head.
out_iface  output  1  interface tag of the head byte: 0=PINT('a'), 1=discrete('c').
out_valid  output  1  FIFO non-empty.
out_ready  input  1  consumer pop; pop occurs when out_valid && out_ready.
frame_start  output  1  one-cycle pulse, header accepted.
frame_done  output  1  one-cycle pulse, frame terminated.
frame_len  output  8  decoded byte count of the last frame, saturating at 255; valid with frame_done, held until the next frame_done.
frame_err  output  1  error flag of the last frame; same timing as frame_len.
overflow  output  1  sticky, a byte was dropped due to a full FIFO; cleared only by reset.

Behaviour:
- Reset (async, resetn=0): state IDLE; FIFO emptied; out_valid=0, out_data=0, out_iface=0, frame_start=0, frame_done=0, frame_len=0, frame_err=0, overflow=0.
- All logic clocks on rising clk. Characters are acted on only in cycles with rx_latch=1.
- Hex set: 0-9, A-F, a-f. CR (0x0d) is ignored in every state.
- States:
  - IDLE:
    - 0x61 -> HI, iface=0, frame_start pulse.
    - 0x63 -> HI, iface=1, frame_start pulse.
    - Any other character is ignored; stay in IDLE.
    - 'a'/'c' are headers only in IDLE; in HI/LO they are hex digits.
  - HI:
    - Hex -> latch upper nibble -> LO.
    - LF -> frame_done -> IDLE. An empty frame is legal: len=0, err=0.
    - Any other character -> err=1 -> DISCARD.
  - LO:
    - Hex -> form byte {hi, lo} and push {iface, byte}; len+1 (saturating at 255) -> HI.
    - LF -> odd nibble count: drop the dangling nibble, frame_done with err=1 -> IDLE.
    - Any other character -> err=1 -> DISCARD.
  - DISCARD:
    - Ignore everything until LF -> frame_done with err=1 -> IDLE.
- Latency:
  - Header strobe in cycle N -> frame_start in N+1.
  - Low-nibble strobe in cycle N -> byte visible (out_valid=1 if the FIFO was empty) in N+1.
  - LF strobe in cycle N -> frame_done in N+1, with frame_len/frame_err updated that same cycle.
- FIFO:
  - Push is accepted if not full, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped: overflow<=1, frame err=1. len still counts the byte; parsing continues.
  - Pop with empty FIFO has no effect.
  - Pointers wrap modulo depth; full/empty are distinguished by an extra pointer bit.
- Simultaneous push and pop on an empty FIFO: no pop; the byte is pushed.
- frame_done does not wait for the FIFO to drain; bytes of consecutive frames queue back-to-back with their own iface tags.
- Internal len and err are cleared on frame_start.

Optional Feature:
PARSER_TIMEOUT_EN
- Defined:
  - A counter resets on every rx_latch and whenever the state is IDLE.
  - If it reaches TIMEOUT_CYCLES while in HI, LO or DISCARD: frame_done with err=1, return to IDLE.
  - A pending nibble is dropped; bytes already pushed remain in the FIFO.
- Undefined: no counter; the parser waits indefinitely for LF.

Test Plan:
- Stream "a12AB\n", out_ready=1 -> bytes 0x12, 0xAB, each with iface=0; frame_start once; frame_done with len=2, err=0.
- Stream "c5\n" -> no byte output; frame_done with len=0, err=1; then "cff\n" -> byte 0xFF, iface=1, len=1, err=0.
- Stream "aZ9\n" -> DISCARD; no bytes; frame_done with err=1; subsequent "a00\n" -> byte 0x00, err=0.
- out_ready=0, stream "a" + 9 pairs "01".."09" + "\n" -> 8 bytes stored, 0x09 dropped; overflow=1; len=9, err=1; draining returns 0x01..0x08.
- Assert resetn=0 mid-frame after "a1" -> all outputs zero immediately; after release, "c3c\n" -> byte 0x3C, iface=1.
- With PARSER_TIMEOUT_EN and TIMEOUT_CYCLES=100: send "a4", then idle 100 cycles -> frame_done with err=1, len=0; state IDLE.
